lcd_pix_fmt_pipe: RTL and testbench

- Parametrised successor to the LCD palette/colour-format stage. Sits between the pixel serialiser and the LCD timing/output block.
- Accepts one pixel per beat on a valid/ready stream and looks up the palette RAM for 1/2/4/8 bpp modes. Expands every mode to a 24-bit panel word for TFT, STN colour or STN mono.
- Pipelined with a configurable palette-RAM latency. Absorbs backpressure through a credit-tracked output FIFO.

---
 rtl/lcd_pix_fmt_pipe.sv | 239 +++++++++++++++++++++++
 tb/tb_lcd_pix_fmt_pipe.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_pix_fmt_pipe.sv
// LCD pixel format pipeline: palette lookup, colour-format expansion and credit-tracked output FIFO.
// Optional build macro LCD_PIX_FMT_STATS_EN adds pix_cnt/frm_cnt output-side statistics.
module lcd_pix_fmt_pipe #(
  parameter int PAL_AW     = 8,
  parameter int PAL_LAT    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic [2:0]        cfg_bpp,
  input  logic              cfg_tft,
  input  logic              cfg_bgr,
  input  logic              cfg_bw,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [23:0]       in_pix,
  input  logic              in_sof,
  output logic [PAL_AW-1:0] pal_raddr,
  input  logic [15:0]       pal_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [23:0]       out_pix,
  output logic              out_sof
`ifdef LCD_PIX_FMT_STATS_EN
  ,
  output logic [31:0]       pix_cnt,
  output logic [15:0]       frm_cnt
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] CRED_MAX = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] C_ONE    = CW'(1);
  localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
  localparam logic [PW-1:0] P_ONE    = PW'(1);

  // Mode tag carried with every beat: {bpp[2:0], tft, bgr, bw}
  typedef logic [5:0] mode_t;

  function automatic logic [23:0] fmt_word(input mode_t m, input logic [23:0] rd);
    logic [2:0]  bpp;
    logic        tft;
    logic        bgr;
    logic        bw;
    logic        inten;
    logic [23:0] w;
    bpp   = m[5:3];
    tft   = m[2];
    bgr   = m[1];
    bw    = m[0];
    inten = rd[15];
    w     = '0;
    if (tft) begin
      case (bpp)
        3'd5:    w = rd;
        3'd6:    w = {rd[15:11], 3'b0, rd[10:5], 2'b0, rd[4:0], 3'b0};
        3'd7:    w = {rd[11:8], 4'b0, rd[7:4], 4'b0, rd[3:0], 4'b0};
        default: w = {rd[14:10], inten, 2'b0, rd[9:5], inten, 2'b0, rd[4:0], inten, 2'b0};
      endcase
    end else if (bw) begin
      w = {20'b0, rd[4:1]};
    end else begin
      w = {4'b0, rd[14:11], 4'b0, rd[9:6], 4'b0, rd[4:1]};
    end
    if (bgr && (tft || !bw)) begin
      w = {w[7:0], w[15:8], w[23:16]};
    end
    return w;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + P_ONE;
  endfunction

  logic              alive_q;
  logic [CW-1:0]     cred_q, cred_d;
  mode_t             shadow_q, shadow_d;
  mode_t             mode_in;
  logic [7:0]        idx;
  logic [PAL_AW-1:0] raddr_q, raddr_d;
  logic              acc;
  logic              push;
  logic              pop;

  assign acc       = in_valid && in_ready;
  assign in_ready  = alive_q && (cred_q != '0);
  assign mode_in   = in_sof ? {cfg_bpp, cfg_tft, cfg_bgr, cfg_bw} : shadow_q;
  assign pal_raddr = raddr_q;

  always_comb begin
    idx      = 8'h00;
    shadow_d = shadow_q;
    raddr_d  = raddr_q;
    cred_d   = cred_q;
    case (mode_in[5:3])
      3'd0:    idx = {7'b0, in_pix[0]};
      3'd1:    idx = {6'b0, in_pix[1:0]};
      3'd2:    idx = {4'b0, in_pix[3:0]};
      default: idx = in_pix[7:0];
    endcase
    if (acc && in_sof) shadow_d = mode_in;
    if (acc && !mode_in[5]) raddr_d = PAL_AW'(idx);
    // Credits count free FIFO slots not yet claimed by beats still in the pipe
    if (acc && !pop) begin
      cred_d = cred_q - C_ONE;
    end else if (!acc && pop) begin
      cred_d = cred_q + C_ONE;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      alive_q  <= 1'b0;
      cred_q   <= CRED_MAX;
      shadow_q <= '0;
      raddr_q  <= '0;
    end else begin
      alive_q  <= 1'b1;
      cred_q   <= cred_d;
      shadow_q <= shadow_d;
      raddr_q  <= raddr_d;
    end
  end

  logic [PAL_LAT:0] st_v_q;
  logic [PAL_LAT:0] st_sof_q;
  mode_t            st_mode_q [0:PAL_LAT];
  logic [23:0]      st_pix_q  [0:PAL_LAT];

  // Stage 0 is the issue stage; stages 1..PAL_LAT track the palette RAM access
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      st_v_q   <= '0;
      st_sof_q <= '0;
      for (int k = 0; k <= PAL_LAT; k++) begin
        st_mode_q[k] <= '0;
        st_pix_q[k]  <= '0;
      end
    end else begin
      st_v_q       <= {st_v_q[PAL_LAT-1:0], acc};
      st_sof_q     <= {st_sof_q[PAL_LAT-1:0], in_sof};
      st_mode_q[0] <= mode_in;
      st_pix_q[0]  <= in_pix;
      for (int k = 1; k <= PAL_LAT; k++) begin
        st_mode_q[k] <= st_mode_q[k-1];
        st_pix_q[k]  <= st_pix_q[k-1];
      end
    end
  end

  logic [23:0] src_word;
  logic        fmt_v_q;
  logic        fmt_sof_q;
  logic [23:0] fmt_pix_q;

  assign src_word = st_mode_q[PAL_LAT][5] ? st_pix_q[PAL_LAT] : {8'h00, pal_rdata};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      fmt_v_q   <= 1'b0;
      fmt_sof_q <= 1'b0;
      fmt_pix_q <= '0;
    end else begin
      fmt_v_q   <= st_v_q[PAL_LAT];
      fmt_sof_q <= st_sof_q[PAL_LAT];
      fmt_pix_q <= fmt_word(st_mode_q[PAL_LAT], src_word);
    end
  end

  logic [24:0]   fifo_mem [0:FIFO_DEPTH-1];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Credits guarantee a free slot for every word leaving the format stage
  assign push      = fmt_v_q;
  assign out_valid = (cnt_q != '0);
  assign pop       = out_valid && out_ready;
  assign {out_sof, out_pix} = out_valid ? fifo_mem[rd_q] : 25'd0;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) wr_d = ptr_inc(wr_q);
    if (pop) rd_d = ptr_inc(rd_q);
    if (push && !pop) begin
      cnt_d = cnt_q + C_ONE;
    end else if (!push && pop) begin
      cnt_d = cnt_q - C_ONE;
    end
  end

  always_ff @(posedge HCLK) begin
    if (push) fifo_mem[wr_q] <= {fmt_sof_q, fmt_pix_q};
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef LCD_PIX_FMT_STATS_EN
  logic [31:0] pix_cnt_q, pix_cnt_d;
  logic [15:0] frm_cnt_q, frm_cnt_d;

  always_comb begin
    pix_cnt_d = pix_cnt_q;
    frm_cnt_d = frm_cnt_q;
    if (pop) begin
      // A sof pop starts a new frame and is itself its first pixel
      pix_cnt_d = out_sof ? 32'd1 : pix_cnt_q + 32'd1;
      if (out_sof) frm_cnt_d = frm_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pix_cnt_q <= '0;
      frm_cnt_q <= '0;
    end else begin
      pix_cnt_q <= pix_cnt_d;
      frm_cnt_q <= frm_cnt_d;
    end
  end

  assign pix_cnt = pix_cnt_q;
  assign frm_cnt = frm_cnt_q;
`endif

endmodule

// File: tb/tb_lcd_pix_fmt_pipe.sv
// Scoreboard bench for lcd_pix_fmt_pipe: driver pushes model results, negedge monitor pops and compares.
module tb_lcd_pix_fmt_pipe;
  localparam int LAT   = 1;
  localparam int DEPTH = 4;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic [2:0]  cfg_bpp = '0;
  logic        cfg_tft = 1'b0;
  logic        cfg_bgr = 1'b0;
  logic        cfg_bw = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_pix = '0;
  logic        in_sof = 1'b0;
  logic [7:0]  pal_raddr;
  logic [15:0] pal_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_pix;
  logic        out_sof;

  logic        rand_rdy = 1'b0;
  logic        rdy_fix = 1'b0;
  logic        rdy_rnd = 1'b0;
  assign out_ready = rand_rdy ? rdy_rnd : rdy_fix;

  lcd_pix_fmt_pipe #(.PAL_AW(8), .PAL_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cfg_bpp(cfg_bpp), .cfg_tft(cfg_tft), .cfg_bgr(cfg_bgr), .cfg_bw(cfg_bw),
    .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix), .in_sof(in_sof),
    .pal_raddr(pal_raddr), .pal_rdata(pal_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pix(out_pix), .out_sof(out_sof)
  );

  always #5 HCLK = ~HCLK;

  // Palette RAM with LAT-cycle read latency
  logic [15:0] pal_mem  [256];
  logic [15:0] pal_pipe [LAT];
  always @(posedge HCLK) begin
    pal_pipe[0] <= pal_mem[pal_raddr];
    for (int k = 1; k < LAT; k++) pal_pipe[k] <= pal_pipe[k-1];
  end
  assign pal_rdata = pal_pipe[LAT-1];

  always @(posedge HCLK) begin
    #1;
    rdy_rnd = ($urandom_range(0, 3) != 0);
  end

  int          tests = 0;
  int          fails = 0;
  logic [24:0] exp_q [$];
  logic [5:0]  shadow = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: unpack colour channels from the source word, scale to 8 bits, pack B:G:R
  function automatic logic [23:0] ref_word(input logic [5:0] m, input logic [23:0] pix);
    int bpp, src, r, g, b, i, t;
    logic [7:0] ix;
    bpp = int'(m[5:3]);
    if (bpp < 4) begin
      ix  = 8'(int'(pix) % (1 << (1 << bpp)));
      src = int'(pal_mem[ix]);
    end else begin
      src = int'(pix);
    end
    i = (src / 32768) % 2;
    if (m[2] == 1'b0) begin
      if (m[0]) return 24'((src / 2) % 16);
      r = (src / 2) % 16;
      g = (src / 64) % 16;
      b = (src / 2048) % 16;
    end else if (bpp == 5) begin
      r = src % 256; g = (src / 256) % 256; b = (src / 65536) % 256;
    end else if (bpp == 6) begin
      r = (src % 32) * 8; g = ((src / 32) % 64) * 4; b = ((src / 2048) % 32) * 8;
    end else if (bpp == 7) begin
      r = (src % 16) * 16; g = ((src / 16) % 16) * 16; b = ((src / 256) % 16) * 16;
    end else begin
      r = (src % 32) * 8 + i * 4;
      g = ((src / 32) % 32) * 8 + i * 4;
      b = ((src / 1024) % 32) * 8 + i * 4;
    end
    if (m[1]) begin
      t = r; r = b; b = t;
    end
    return 24'(b * 65536 + g * 256 + r);
  endfunction

  task automatic try_beat(input logic [2:0] bpp, input logic tft, input logic bgr, input logic bw,
                          input logic sof, input logic [23:0] pix, output bit ok);
    cfg_bpp = bpp; cfg_tft = tft; cfg_bgr = bgr; cfg_bw = bw;
    in_sof = sof; in_pix = pix; in_valid = 1'b1;
    @(negedge HCLK);
    ok = in_ready;
    if (ok) begin
      if (sof) shadow = {bpp, tft, bgr, bw};
      exp_q.push_back({sof, ref_word(shadow, pix)});
    end
    @(posedge HCLK);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [2:0] bpp, input logic tft, input logic bgr, input logic bw,
                      input logic sof, input logic [23:0] pix);
    bit ok = 1'b0;
    int n = 0;
    while (!ok && n < 200) begin
      try_beat(bpp, tft, bgr, bw, sof, pix, ok);
      n++;
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL accept_timeout: got no acceptance expected acceptance within 200 cycles");
    end
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(posedge HCLK);
      #1;
      lat++;
    end while (!out_valid && lat < 50);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 500) begin
      @(posedge HCLK);
      #1;
      n++;
    end
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  logic        stall_prev = 1'b0;
  logic [23:0] prev_pix = '0;
  logic [24:0] e;
  always @(negedge HCLK) begin
    if (!HRESETn) begin
      stall_prev = 1'b0;
    end else begin
      if (out_valid && stall_prev) check("hold_stable", 32'(out_pix), 32'(prev_pix));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_out: got %h expected no word", out_pix);
        end else begin
          e = exp_q.pop_front();
          check("out_word", 32'({out_sof, out_pix}), 32'(e));
        end
      end
      if (exp_q.size() != 0) check("occupancy_le_depth", 32'(exp_q.size() <= DEPTH), 32'd1);
      stall_prev = out_valid && !out_ready;
      prev_pix   = out_pix;
    end
  end

  initial begin
    int lat;
    int nacc;
    bit ok;
    for (int i = 0; i < 256; i++) pal_mem[i] = 16'($urandom);
    pal_mem[8'h5A] = 16'hFC01;
    pal_mem[8'h01] = 16'h001E;
    repeat (3) @(posedge HCLK);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_pix", 32'(out_pix), 32'd0);
    check("rst_out_sof", 32'(out_sof), 32'd0);
    check("rst_pal_raddr", 32'(pal_raddr), 32'd0);
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
    check("ready_after_reset", 32'(in_ready), 32'd1);
    rdy_fix = 1'b1;

    send(3'd6, 1'b1, 1'b0, 1'b0, 1'b1, 24'h00F81F);
    wait_out(lat);
    check("latency_565", 32'(lat), 32'd3);
    check("pix_565", 32'(out_pix), 32'hF800F8);
    drain();

    send(3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 24'h12345A);
    check("pal_raddr_8bpp", 32'(pal_raddr), 32'h5A);
    wait_out(lat);
    check("pix_8bpp_1555", 32'(out_pix), 32'hFC040C);
    drain();
    send(3'd3, 1'b1, 1'b1, 1'b0, 1'b1, 24'h00005A);
    wait_out(lat);
    check("pix_8bpp_bgr", 32'(out_pix), 32'h0C04FC);
    drain();

    send(3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 24'h123451);
    check("pal_raddr_1bpp", 32'(pal_raddr), 32'h01);
    wait_out(lat);
    check("pix_stn_mono", 32'(out_pix), 32'h00000F);
    drain();

    rdy_fix = 1'b0;
    nacc = 0;
    for (int c = 0; c < 12; c++) begin
      try_beat(3'd5, 1'b1, 1'b0, 1'b0, (nacc == 0), 24'(32'h100 + nacc), ok);
      if (ok) nacc++;
    end
    check("bp_accepts", 32'(nacc), 32'd4);
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    rdy_fix = 1'b1;
    for (int k = nacc; k < 10; k++) send(3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 24'(32'h100 + k));
    drain();

    send(3'd5, 1'b1, 1'b0, 1'b0, 1'b1, 24'($urandom));
    send(3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 24'($urandom));
    send(3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 24'($urandom));
    send(3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 24'hA5F81F);
    send(3'd6, 1'b1, 1'b0, 1'b0, 1'b1, 24'($urandom));
    send(3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 24'($urandom));
    send(3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 24'($urandom));
    drain();

    rdy_fix = 1'b0;
    send(3'd5, 1'b1, 1'b0, 1'b0, 1'b1, 24'h111111);
    send(3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 24'h222222);
    send(3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 24'h333333);
    repeat (4) @(posedge HCLK);
    #1;
    check("pre_reset_out_valid", 32'(out_valid), 32'd1);
    #2;
    HRESETn = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_pix", 32'(out_pix), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    exp_q.delete();
    shadow = '0;
    repeat (2) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
    check("postrst_in_ready", 32'(in_ready), 32'd1);
    check("postrst_pal_raddr", 32'(pal_raddr), 32'd0);
    check("postrst_out_valid", 32'(out_valid), 32'd0);
    nacc = 0;
    for (int c = 0; c < 8; c++) begin
      try_beat(3'd7, 1'b1, 1'b0, 1'b0, (nacc == 0), 24'(32'h0ABC + nacc), ok);
      if (ok) nacc++;
    end
    check("postrst_credits", 32'(nacc), 32'd4);
    rdy_fix = 1'b1;
    drain();

    rand_rdy = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge HCLK);
        #1;
      end
      send(3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'($urandom),
           (n == 0) || ($urandom_range(0, 7) == 0), 24'($urandom));
    end
    @(posedge HCLK);
    #1;
    rand_rdy = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected finish before 1ms");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end
endmodule
